// File: rtl/adv_drc_axi_sink.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : adv_drc_axi_sink
// Purpose  : AXI4 write responder that turns 128-bit INCR bursts into path-side
//            burst descriptors and 132-bit data FIFO words.
// Revision : 1.0
// ============================================================================
module adv_drc_axi_sink #(
    parameter int p_id_bits      = 1,
    parameter int p_err_cnt_bits = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [31:0]               awaddr,
    input  logic [7:0]                awlen,
    input  logic [2:0]                awsize,
    input  logic [1:0]                awburst,
    input  logic [p_id_bits-1:0]      awid,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [127:0]              wdata,
    input  logic [15:0]               wstrb,
    input  logic                      wlast,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [1:0]                bresp,
    output logic [p_id_bits-1:0]      bid,
    output logic                      bvalid,
    input  logic                      bready,
    output logic [39:0]               burst_out,
    output logic                      burst_wr,
    input  logic                      burst_full,
    output logic [131:0]              data_out,
    output logic                      data_wr,
    input  logic                      data_full,
    output logic [p_err_cnt_bits-1:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [7:0]                  beat_ctr_q, beat_ctr_d;
    logic                        drop_q, drop_d;
    logic                        err_q, err_d;
    logic [p_id_bits-1:0]        bid_q, bid_d;
    logic                        bvalid_q, bvalid_d;
    logic [1:0]                  bresp_q, bresp_d;
    logic [p_err_cnt_bits-1:0]   err_cnt_q, err_cnt_d;
    logic                        burst_wr_q, burst_wr_d;
    logic [39:0]                 burst_out_q, burst_out_d;
    logic                        data_wr_q, data_wr_d;
    logic [131:0]                data_out_q, data_out_d;

    logic aw_hs, w_hs, b_hs;
    logic bad_fmt, cnt_final, beat_final, beat_err;

    assign awready = (state_q == ST_IDLE) && !burst_full;
    assign wready  = (state_q == ST_DATA) && (drop_q || !data_full);

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign b_hs  = bvalid_q && bready;

    assign bad_fmt    = (awsize != 3'b100) || (awburst != 2'b01);
    assign cnt_final  = (beat_ctr_q == 8'd0);
    // An early wlast also closes the burst; either disagreement is an error.
    assign beat_final = cnt_final || wlast;
    assign beat_err   = (cnt_final != wlast);

    always_comb begin
        state_d     = state_q;
        beat_ctr_d  = beat_ctr_q;
        drop_d      = drop_q;
        err_d       = err_q;
        bid_d       = bid_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        err_cnt_d   = err_cnt_q;
        burst_wr_d  = 1'b0;
        burst_out_d = burst_out_q;
        data_wr_d   = 1'b0;
        data_out_d  = data_out_q;

        case (state_q)
            ST_IDLE: begin
                if (aw_hs) begin
                    bid_d      = awid;
                    beat_ctr_d = awlen;
                    err_d      = 1'b0;
                    drop_d     = bad_fmt;
                    if (!bad_fmt) begin
                        burst_wr_d  = 1'b1;
                        burst_out_d = {awaddr, awlen + 8'd1};
                    end
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_hs) begin
                    if (!drop_q) begin
                        data_wr_d  = 1'b1;
                        data_out_d = {2'b00, (wstrb != 16'hFFFF), wlast, wdata};
                    end
                    beat_ctr_d = beat_ctr_q - 8'd1;
                    if (beat_err) begin
                        err_d = 1'b1;
                    end
                    if (beat_final) begin
                        state_d  = ST_RESP;
                        bvalid_d = 1'b1;
                        bresp_d  = (drop_q || err_q || beat_err) ? 2'b10 : 2'b00;
                    end
                end
            end
            ST_RESP: begin
                if (b_hs) begin
                    bvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                    if ((bresp_q == 2'b10) && (err_cnt_q != {p_err_cnt_bits{1'b1}})) begin
                        err_cnt_d = err_cnt_q + p_err_cnt_bits'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            beat_ctr_q  <= 8'd0;
            drop_q      <= 1'b0;
            err_q       <= 1'b0;
            bid_q       <= '0;
            bvalid_q    <= 1'b0;
            bresp_q     <= 2'b00;
            err_cnt_q   <= '0;
            burst_wr_q  <= 1'b0;
            burst_out_q <= 40'd0;
            data_wr_q   <= 1'b0;
            data_out_q  <= 132'd0;
        end else begin
            state_q     <= state_d;
            beat_ctr_q  <= beat_ctr_d;
            drop_q      <= drop_d;
            err_q       <= err_d;
            bid_q       <= bid_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            err_cnt_q   <= err_cnt_d;
            burst_wr_q  <= burst_wr_d;
            burst_out_q <= burst_out_d;
            data_wr_q   <= data_wr_d;
            data_out_q  <= data_out_d;
        end
    end

    assign bresp     = bresp_q;
    assign bid       = bid_q;
    assign bvalid    = bvalid_q;
    assign burst_out = burst_out_q;
    assign burst_wr  = burst_wr_q;
    assign data_out  = data_out_q;
    assign data_wr   = data_wr_q;
    assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_adv_drc_axi_sink.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for adv_drc_axi_sink: directed bursts plus randomized traffic, checked
// every cycle against a transaction-level reference model.
module tb_adv_drc_axi_sink;
    localparam int IDB = 1;
    localparam int ECB = 16;

    logic           i_clk = 1'b0;
    logic           i_rst = 1'b1;
    logic [31:0]    awaddr = '0;
    logic [7:0]     awlen = '0;
    logic [2:0]     awsize = '0;
    logic [1:0]     awburst = '0;
    logic [IDB-1:0] awid = '0;
    logic           awvalid = 1'b0;
    logic           awready;
    logic [127:0]   wdata = '0;
    logic [15:0]    wstrb = '0;
    logic           wlast = 1'b0;
    logic           wvalid = 1'b0;
    logic           wready;
    logic [1:0]     bresp;
    logic [IDB-1:0] bid;
    logic           bvalid;
    logic           bready = 1'b0;
    logic [39:0]    burst_out;
    logic           burst_wr;
    logic           burst_full = 1'b0;
    logic [131:0]   data_out;
    logic           data_wr;
    logic           data_full = 1'b0;
    logic [ECB-1:0] err_cnt;

    adv_drc_axi_sink #(.p_id_bits(IDB), .p_err_cnt_bits(ECB)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awid(awid), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bid(bid), .bvalid(bvalid), .bready(bready),
        .burst_out(burst_out), .burst_wr(burst_wr), .burst_full(burst_full),
        .data_out(data_out), .data_wr(data_wr), .data_full(data_full),
        .err_cnt(err_cnt)
    );

    always #5 i_clk = ~i_clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [131:0] act, input logic [131:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    // Transaction-level reference: 0=waiting for address, 1=collecting beats, 2=responding
    int             m_phase = 0;
    int             m_total = 0;
    int             m_seen = 0;
    bit             m_drop = 0;
    bit             m_err = 0;
    logic [IDB-1:0] m_bid = '0;
    logic [1:0]     m_bresp = 2'b00;
    bit             m_bwr = 0;
    bit             m_dwr = 0;
    logic [39:0]    m_bout = '0;
    logic [131:0]   m_dout = '0;
    int             m_errcnt = 0;

    // Observed statistics for the directed checks
    int             n_bwr = 0, n_dwr = 0, n_last = 0, last_pos = 0, n_b = 0;
    logic [39:0]    last_bout = '0;
    logic [1:0]     last_bresp = 2'b11;
    logic [IDB-1:0] last_bid = '0;

    always @(negedge i_clk) begin
        chk("awready", awready, (m_phase == 0) && !burst_full);
        chk("wready", wready, (m_phase == 1) && (m_drop || !data_full));
        chk("burst_wr", burst_wr, m_bwr);
        if (m_bwr) chk("burst_out", burst_out, m_bout);
        chk("data_wr", data_wr, m_dwr);
        if (m_dwr) chk("data_out", data_out, m_dout);
        chk("bvalid", bvalid, m_phase == 2);
        if (m_phase == 2) begin
            chk("bresp", bresp, m_bresp);
            chk("bid", bid, m_bid);
        end
        chk("err_cnt", err_cnt, m_errcnt);

        if (burst_wr) begin n_bwr++; last_bout = burst_out; end
        if (data_wr) begin
            n_dwr++;
            if (data_out[128]) begin n_last++; last_pos = n_dwr; end
        end
        if (bvalid && bready) begin n_b++; last_bresp = bresp; last_bid = bid; end

        m_bwr = 0;
        m_dwr = 0;
        if (i_rst) begin
            m_phase = 0; m_errcnt = 0; m_bid = '0; m_bresp = 2'b00;
            m_drop = 0; m_err = 0;
        end else begin
            case (m_phase)
                0: if (awvalid && !burst_full) begin
                    m_bid   = awid;
                    m_total = int'(awlen) + 1;
                    m_seen  = 0;
                    m_err   = 0;
                    m_drop  = (awsize != 3'b100) || (awburst != 2'b01);
                    if (!m_drop) begin
                        m_bwr  = 1;
                        m_bout = {awaddr, 8'((m_total) % 256)};
                    end
                    m_phase = 1;
                end
                1: if (wvalid && (m_drop || !data_full)) begin
                    if (!m_drop) begin
                        m_dwr  = 1;
                        m_dout = {2'b00, (wstrb != 16'hFFFF), wlast, wdata};
                    end
                    m_seen++;
                    if ((m_seen == m_total) != wlast) m_err = 1;
                    if ((m_seen == m_total) || wlast) begin
                        m_phase = 2;
                        m_bresp = (m_drop || m_err) ? 2'b10 : 2'b00;
                    end
                end
                2: if (bready) begin
                    m_phase = 0;
                    if (m_bresp == 2'b10 && m_errcnt < (2**ECB - 1)) m_errcnt++;
                end
                default: m_phase = 0;
            endcase
        end
    end

    bit full_rand = 0;
    bit bf_rand = 0;
    always @(posedge i_clk) begin
        #1;
        if (full_rand) data_full = ($urandom % 3 == 0);
        if (bf_rand) burst_full = ($urandom % 4 == 0);
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_stats();
        n_bwr = 0; n_dwr = 0; n_last = 0; last_pos = 0; n_b = 0;
        last_bresp = 2'b11;
    endtask

    task automatic do_aw(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] bt, input logic [IDB-1:0] id);
        int t;
        awaddr = a; awlen = len; awsize = sz; awburst = bt; awid = id; awvalid = 1'b1;
        for (t = 0; t < 300; t++) begin
            @(negedge i_clk);
            if (awready) break;
        end
        if (t == 300) timeout_fail("aw_handshake");
        tick();
        awvalid = 1'b0;
    endtask

    task automatic send_beats(input int n, input int last_idx, input bit gaps);
        int t;
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom % 3 == 0)) begin
                wvalid = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
            end
            wdata  = {$urandom, $urandom, $urandom, $urandom};
            wstrb  = ($urandom % 4 == 0) ? 16'($urandom) : 16'hFFFF;
            wlast  = (i == last_idx);
            wvalid = 1'b1;
            for (t = 0; t < 300; t++) begin
                @(negedge i_clk);
                if (wready) break;
            end
            if (t == 300) timeout_fail("w_handshake");
            tick();
            wvalid = 1'b0;
            wlast  = 1'b0;
        end
    endtask

    task automatic wait_b(input int hold);
        int t;
        bready = 1'b0;
        repeat (hold) tick();
        bready = 1'b1;
        for (t = 0; t < 300; t++) begin
            @(negedge i_clk);
            if (bvalid) break;
        end
        if (t == 300) timeout_fail("b_handshake");
        tick();
        bready = 1'b0;
    endtask

    task automatic burst(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] bt, input logic [IDB-1:0] id,
                         input int nsend, input int last_idx, input bit gaps, input int hold);
        do_aw(a, len, sz, bt, id);
        send_beats(nsend, last_idx, gaps);
        wait_b(hold);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_bresp", bresp, 2'b00);
        chk("rst_bid", bid, 1'b0);
        chk("rst_burst_wr", burst_wr, 1'b0);
        chk("rst_data_wr", data_wr, 1'b0);
        chk("rst_err_cnt", err_cnt, 16'd0);
        i_rst = 1'b0;
        tick();

        // Basic 4-beat burst
        clear_stats();
        burst(32'h1000, 8'd3, 3'b100, 2'b01, 1'b1, 4, 3, 0, 0);
        chk("t1_n_burst", n_bwr, 1);
        chk("t1_desc", last_bout, 40'h00001000_04);
        chk("t1_n_data", n_dwr, 4);
        chk("t1_n_last", n_last, 1);
        chk("t1_last_pos", last_pos, 4);
        chk("t1_bresp", last_bresp, 2'b00);
        chk("t1_bid", last_bid, 1'b1);

        // 256-beat burst with gaps and data_full toggling
        clear_stats();
        full_rand = 1;
        burst(32'hA000_0000, 8'd255, 3'b100, 2'b01, 1'b0, 256, 255, 1, 0);
        full_rand = 0;
        data_full = 1'b0;
        chk("t2_n_data", n_dwr, 256);
        chk("t2_n_burst", n_bwr, 1);
        chk("t2_len_byte", last_bout[7:0], 8'h00);
        chk("t2_bresp", last_bresp, 2'b00);

        // FIXED burst is dropped even with data FIFO full
        clear_stats();
        data_full = 1'b1;
        burst(32'h2000, 8'd1, 3'b100, 2'b00, 1'b0, 2, 1, 0, 0);
        data_full = 1'b0;
        chk("t3_n_burst", n_bwr, 0);
        chk("t3_n_data", n_dwr, 0);
        chk("t3_bresp", last_bresp, 2'b10);
        chk("t3_err_cnt", err_cnt, 16'd1);

        // Early wlast, then a clean burst
        clear_stats();
        burst(32'h3000, 8'd3, 3'b100, 2'b01, 1'b1, 2, 1, 0, 0);
        chk("t4_n_data", n_dwr, 2);
        chk("t4_bresp", last_bresp, 2'b10);
        chk("t4_err_cnt", err_cnt, 16'd2);
        burst(32'h3100, 8'd2, 3'b100, 2'b01, 1'b0, 3, 2, 0, 0);
        chk("t4b_bresp", last_bresp, 2'b00);

        // Response back-pressure
        burst(32'h4000, 8'd0, 3'b100, 2'b01, 1'b1, 1, 0, 0, 11);
        chk("t5_bid", last_bid, 1'b1);
        chk("t5_bresp", last_bresp, 2'b00);
        @(negedge i_clk);
        chk("t5_awready_after_b", awready, 1'b1);
        tick();

        // Reset in the middle of a burst
        do_aw(32'h5000, 8'd3, 3'b100, 2'b01, 1'b1);
        send_beats(2, -1, 0);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("t6_bvalid", bvalid, 1'b0);
        chk("t6_burst_wr", burst_wr, 1'b0);
        chk("t6_data_wr", data_wr, 1'b0);
        chk("t6_err_cnt", err_cnt, 16'd0);
        chk("t6_awready", awready, 1'b1);
        clear_stats();
        burst(32'h6000, 8'd3, 3'b100, 2'b01, 1'b0, 4, 3, 0, 0);
        chk("t6_n_data", n_dwr, 4);
        chk("t6_bresp", last_bresp, 2'b00);
        chk("t6_err_cnt2", err_cnt, 16'd0);

        // Randomized traffic
        full_rand = 1;
        bf_rand = 1;
        for (int k = 0; k < 25; k++) begin
            int len, last_idx, nsend;
            logic [2:0] sz;
            logic [1:0] bt;
            len = $urandom_range(0, 7);
            sz = 3'b100;
            bt = 2'b01;
            if ($urandom % 4 == 0) begin
                if ($urandom % 2 == 0) bt = 2'(($urandom % 2 == 0) ? 0 : 2);
                else sz = 3'b010;
            end
            if (len > 0 && ($urandom % 4 == 0)) last_idx = $urandom_range(0, len - 1);
            else if ($urandom % 6 == 0) last_idx = -1;
            else last_idx = len;
            nsend = (last_idx >= 0) ? last_idx + 1 : len + 1;
            burst($urandom, 8'(len), sz, bt, IDB'($urandom), nsend, last_idx, 1,
                  $urandom_range(0, 3));
        end
        full_rand = 0;
        bf_rand = 0;
        data_full = 1'b0;
        burst_full = 1'b0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
